alu_wb_stage: RTL and testbench

//  Execute-to-writeback stage directly downstream of the Gumnut ALU.
//  - Captures the ALU result C and the status outputs cout/Ov/Neg/Zero.
//  - Holds the architectural condition-code register (Z,C,N,V).
//  - Buffers register-file writes in a 2-entry skid queue.
//  - Evaluates branch conditions against the held flags.

---
 rtl/alu_wb_stage.sv | 135 +++++++++++++
 tb/tb_alu_wb_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/alu_wb_stage.sv
// Execute-to-writeback stage behind the Gumnut ALU: captures ALU results,
// holds the {Z,C,N,V} condition codes, buffers register-file writes in a
// 2-entry skid queue and evaluates branch conditions.
// Optional build macro: ALU_FLAG_FWD_EN (br_taken sees next-state flags).
module alu_wb_stage #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned RADDR_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  alu_c,
  input  logic               alu_cout,
  input  logic               alu_ov,
  input  logic               alu_neg,
  input  logic               alu_zero,
  input  logic [2:0]         alu_op,
  input  logic [RADDR_W-1:0] rd,
  input  logic               wr_en,
  input  logic               upd_flags,
  input  logic               flag_ld,
  input  logic [3:0]         flag_ld_val,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]  rf_wdata,
  output logic [3:0]         flags,
  input  logic [1:0]         br_cond,
  input  logic               br_inv,
  output logic               br_taken,
  output logic [1:0]         occ
);

  localparam int unsigned OCC_W = 2;
  localparam int unsigned FL_W  = 4;

  // Queue storage: slot 0 is the head and drives the register-file port.
  logic [RADDR_W-1:0] head_addr, tail_addr;
  logic [DATA_W-1:0]  head_data, tail_data;
  logic [RADDR_W-1:0] nxt_head_addr, nxt_tail_addr;
  logic [DATA_W-1:0]  nxt_head_data, nxt_tail_data;
  logic [OCC_W-1:0]   nxt_occ;
  logic [FL_W-1:0]    nxt_flags;
  logic               accept, pop, enq;
  logic [1:0]         br_idx;
  logic [FL_W-1:0]    br_src;

  assign out_valid = (occ != OCC_W'(0));
  assign pop       = out_valid & out_ready;
  assign in_ready  = (occ != OCC_W'(2)) | pop;
  assign accept    = in_valid & in_ready;
  assign enq       = accept & wr_en;
  assign rf_waddr  = head_addr;
  assign rf_wdata  = head_data;

  // Next-state queue contents and occupancy for enqueue/pop combinations.
  always_comb begin
    nxt_occ       = occ;
    nxt_head_addr = head_addr;
    nxt_head_data = head_data;
    nxt_tail_addr = tail_addr;
    nxt_tail_data = tail_data;
    case ({enq, pop})
      2'b10: begin
        if (occ == OCC_W'(0)) begin
          nxt_head_addr = rd;
          nxt_head_data = alu_c;
        end else begin
          nxt_tail_addr = rd;
          nxt_tail_data = alu_c;
        end
        nxt_occ = occ + OCC_W'(1);
      end
      2'b01: begin
        nxt_head_addr = tail_addr;
        nxt_head_data = tail_data;
        nxt_occ       = occ - OCC_W'(1);
      end
      2'b11: begin
        if (occ == OCC_W'(1)) begin
          nxt_head_addr = rd;
          nxt_head_data = alu_c;
        end else begin
          nxt_head_addr = tail_addr;
          nxt_head_data = tail_data;
          nxt_tail_addr = rd;
          nxt_tail_data = alu_c;
        end
      end
      default: ;
    endcase
  end

  // Next-state condition codes; a context-restore load overrides the ALU update.
  always_comb begin
    nxt_flags = flags;
    if (accept && upd_flags) begin
      nxt_flags[3] = alu_zero;
      nxt_flags[2] = alu_cout;
      nxt_flags[1] = alu_neg;
      if (alu_op[2:1] == 2'b00) nxt_flags[0] = alu_ov;
    end
    if (flag_ld) nxt_flags = flag_ld_val;
  end

  // Queue and flag state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ       <= '0;
      head_addr <= '0;
      head_data <= '0;
      tail_addr <= '0;
      tail_data <= '0;
      flags     <= '0;
    end else begin
      occ       <= nxt_occ;
      head_addr <= nxt_head_addr;
      head_data <= nxt_head_data;
      tail_addr <= nxt_tail_addr;
      tail_data <= nxt_tail_data;
      flags     <= nxt_flags;
    end
  end

  // Branch evaluation: br_cond 00..11 selects Z,C,N,V = bit 3..0.
  assign br_idx = ~br_cond;
`ifdef ALU_FLAG_FWD_EN
  assign br_src = nxt_flags;
`else
  assign br_src = flags;
`endif
  assign br_taken = br_src[br_idx] ^ br_inv;

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed bench for alu_wb_stage.
module tb_alu_wb_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [7:0] alu_c;
  logic       alu_cout, alu_ov, alu_neg, alu_zero;
  logic [2:0] alu_op;
  logic [2:0] rd;
  logic       wr_en, upd_flags, flag_ld;
  logic [3:0] flag_ld_val;
  logic       out_valid, out_ready;
  logic [2:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic [3:0] flags;
  logic [1:0] br_cond;
  logic       br_inv, br_taken;
  logic [1:0] occ;

  int checks = 0;
  int errors = 0;

  alu_wb_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_c(alu_c), .alu_cout(alu_cout), .alu_ov(alu_ov), .alu_neg(alu_neg),
    .alu_zero(alu_zero), .alu_op(alu_op), .rd(rd), .wr_en(wr_en),
    .upd_flags(upd_flags), .flag_ld(flag_ld), .flag_ld_val(flag_ld_val),
    .out_valid(out_valid), .out_ready(out_ready), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .flags(flags), .br_cond(br_cond), .br_inv(br_inv),
    .br_taken(br_taken), .occ(occ)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; alu_c = 0; alu_cout = 0; alu_ov = 0; alu_neg = 0; alu_zero = 0;
    alu_op = 0; rd = 0; wr_en = 0; upd_flags = 0; flag_ld = 0; flag_ld_val = 0;
    br_cond = 0; br_inv = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; out_ready = 0;
    idle_inputs();
    #12;
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occ); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", flags); end
    cyc(); rst_n = 1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    // Fill queue and set flags, then reset mid-transfer.
    in_valid = 1; wr_en = 1; rd = 3'd5; alu_c = 8'hAA;
    flag_ld = 1; flag_ld_val = 4'b1111;
    cyc();
    flag_ld = 0; rd = 3'd6; alu_c = 8'hBB;
    cyc();
    in_valid = 0; out_ready = 1;
    checks++; if (occ !== 2'd2) begin errors++; $display("FAIL prefill_occ got %0d exp 2", occ); end
    checks++; if (flags !== 4'b1111) begin errors++; $display("FAIL prefill_flags got %b exp 1111", flags); end
    rst_n = 0; #1;
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL midreset_occ got %0d exp 0", occ); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid got %b exp 0", out_valid); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL midreset_flags got %b exp 0000", flags); end
    checks++; if (rf_waddr !== 3'd0 || rf_wdata !== 8'h00) begin errors++; $display("FAIL midreset_head got %0d/%h exp 0/00", rf_waddr, rf_wdata); end
    #3; rst_n = 1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b exp 1", in_ready); end
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_no_write got %b exp 0", out_valid); end
  endtask

  task automatic test_add_writeback();
    idle_inputs(); out_ready = 1;
    in_valid = 1; alu_c = 8'h23; rd = 3'd3; wr_en = 1; upd_flags = 1; alu_op = 3'b000;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_no_comb_path got %b exp 0", out_valid); end
    cyc();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_out_valid got %b exp 1", out_valid); end
    checks++; if (rf_waddr !== 3'd3) begin errors++; $display("FAIL add_waddr got %0d exp 3", rf_waddr); end
    checks++; if (rf_wdata !== 8'h23) begin errors++; $display("FAIL add_wdata got %h exp 23", rf_wdata); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL add_flags got %b exp 0000", flags); end
    cyc();
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL add_drain_occ got %0d exp 0", occ); end
  endtask

  task automatic test_backpressure();
    idle_inputs(); out_ready = 0;
    in_valid = 1; wr_en = 1; rd = 3'd1; alu_c = 8'h10;
    cyc();
    rd = 3'd2; alu_c = 8'h20;
    cyc();
    rd = 3'd4; alu_c = 8'h30;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
    checks++; if (occ !== 2'd2) begin errors++; $display("FAIL bp_occ got %0d exp 2", occ); end
    cyc();
    checks++; if (occ !== 2'd2 || rf_wdata !== 8'h10) begin errors++; $display("FAIL bp_hold got %0d/%h exp 2/10", occ, rf_wdata); end
    out_ready = 1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_full_accept got %b exp 1", in_ready); end
    cyc();
    in_valid = 0;
    checks++; if (occ !== 2'd2 || rf_waddr !== 3'd2 || rf_wdata !== 8'h20) begin errors++; $display("FAIL bp_second got %0d/%0d/%h exp 2/2/20", occ, rf_waddr, rf_wdata); end
    cyc();
    checks++; if (occ !== 2'd1 || rf_waddr !== 3'd4 || rf_wdata !== 8'h30) begin errors++; $display("FAIL bp_third got %0d/%0d/%h exp 1/4/30", occ, rf_waddr, rf_wdata); end
    cyc();
    checks++; if (occ !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %0d/%b exp 0/0", occ, out_valid); end
  endtask

  task automatic test_v_hold();
    idle_inputs(); out_ready = 1;
    in_valid = 1; upd_flags = 1; alu_op = 3'b000; alu_ov = 1;
    cyc();
    checks++; if (flags !== 4'b0001) begin errors++; $display("FAIL vset_flags got %b exp 0001", flags); end
    alu_op = 3'b100; alu_ov = 0; alu_cout = 1;
    cyc();
    in_valid = 0;
    checks++; if (flags !== 4'b0101) begin errors++; $display("FAIL vhold_flags got %b exp 0101", flags); end
  endtask

  task automatic test_flag_only();
    idle_inputs(); out_ready = 0;
    in_valid = 1; wr_en = 1; rd = 3'd7; alu_c = 8'h55;
    cyc();
    wr_en = 0; upd_flags = 1; alu_zero = 1; alu_op = 3'b100; alu_c = 8'h00;
    cyc();
    idle_inputs(); br_cond = 2'b00; br_inv = 1; #1;
    checks++; if (occ !== 2'd1 || rf_wdata !== 8'h55) begin errors++; $display("FAIL flagonly_occ got %0d/%h exp 1/55", occ, rf_wdata); end
    checks++; if (flags !== 4'b1001) begin errors++; $display("FAIL flagonly_flags got %b exp 1001", flags); end
    checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL flagonly_br got %b exp 0", br_taken); end
    out_ready = 1;
    cyc();
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL flagonly_drain got %0d exp 0", occ); end
  endtask

  task automatic test_priority_fwd();
    logic exp_same;
    logic [3:0] fl;
    idle_inputs(); out_ready = 1;
    flag_ld = 1; flag_ld_val = 4'b0100;
    in_valid = 1; upd_flags = 1; alu_zero = 1; alu_op = 3'b000;
    br_cond = 2'b01; br_inv = 0; #1;
`ifdef ALU_FLAG_FWD_EN
    exp_same = 1'b1;
`else
    exp_same = 1'b0;
`endif
    checks++; if (br_taken !== exp_same) begin errors++; $display("FAIL prio_br_same got %b exp %b", br_taken, exp_same); end
    cyc();
    flag_ld = 0; in_valid = 0; upd_flags = 0; alu_zero = 0; #1;
    checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL prio_flags got %b exp 0100", flags); end
    checks++; if (br_taken !== 1'b1) begin errors++; $display("FAIL prio_br_next got %b exp 1", br_taken); end
    fl = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      for (int v = 0; v < 2; v++) begin
        br_cond = 2'(c); br_inv = 1'(v); #1;
        checks++;
        if (br_taken !== (fl[3 - c] ^ 1'(v))) begin
          errors++; $display("FAIL br_sel c=%0d inv=%0d got %b exp %b", c, v, br_taken, fl[3 - c] ^ 1'(v));
        end
      end
    end
  endtask

  task automatic test_flag_ld_full();
    idle_inputs(); out_ready = 0;
    in_valid = 1; wr_en = 1; rd = 3'd1; alu_c = 8'h01;
    cyc(); cyc();
    rd = 3'd2; alu_c = 8'h99; upd_flags = 1; alu_op = 3'b000; alu_zero = 0;
    flag_ld = 1; flag_ld_val = 4'b1010;
    cyc();
    checks++; if (flags !== 4'b1010) begin errors++; $display("FAIL ldfull_flags got %b exp 1010", flags); end
    checks++; if (occ !== 2'd2 || in_ready !== 1'b0) begin errors++; $display("FAIL ldfull_occ got %0d/%b exp 2/0", occ, in_ready); end
    idle_inputs(); out_ready = 1;
    cyc(); cyc();
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL ldfull_drain got %0d exp 0", occ); end
  endtask

  initial begin
    test_reset();
    test_add_writeback();
    test_backpressure();
    test_v_hold();
    test_flag_only();
    test_priority_fwd();
    test_flag_ld_full();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
